boot_loader: RTL



---
 rtl/boot_pkg.sv | 19 +
 rtl/boot_checksum.sv | 35 +++
 rtl/boot_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and default widths for the boot loader.
// Revision: 1.0
`default_nettype none

package boot_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CHECK   = 2'd2,
    RELEASE = 2'd3
  } boot_state_t;

endpackage

`default_nettype wire

// File: rtl/boot_checksum.sv
// boot_checksum: modulo-2^DATA_W running sum with clear, add-enable and compare.
// Revision: 1.0
`default_nettype none

module boot_checksum
  import boot_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  input  logic [DATA_W-1:0] cmp_data,
  output logic              mismatch
);

  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

  assign mismatch = (sum != cmp_data);

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// boot_loader: streams len host words into instruction memory from address 0, then
// releases the core. Optional checksum word verification with BOOT_CHECKSUM_EN. Revision: 1.0
`default_nettype none

module boot_loader
  import boot_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              boot_up,
  output logic              boot_web,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [DATA_W-1:0] boot_datai,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  boot_state_t state, next_state;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len_clamped;
  logic              hs;
  logic              last_word;
  logic              accept_start;

  logic              ready_d;
  logic              up_d;
  logic              web_d;
  logic              done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  assign hs           = s_valid & s_ready;
  assign last_word    = ((cnt + ONE) == len_q);
  assign len_clamped  = (len > MAX_LEN) ? MAX_LEN : len;
  assign accept_start = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (len == '0) ? RELEASE : LOAD;
        end
      end
      LOAD: begin
        if (hs && last_word) begin
`ifdef BOOT_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = RELEASE;
`endif
        end
      end
      CHECK: begin
`ifdef BOOT_CHECKSUM_EN
        if (hs) begin
          next_state = RELEASE;
        end
`else
        next_state = IDLE;
`endif
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so s_ready drops on the very edge that
  // accepts the final word, never admitting an extra one.
  always_comb begin
    ready_d = (next_state == LOAD) || (next_state == CHECK);
    up_d    = (next_state != IDLE);
    web_d   = 1'b1;
    done_d  = (state == RELEASE);
    addr_d  = boot_addr;
    data_d  = boot_datai;
    if ((state == LOAD) && hs) begin
      web_d  = 1'b0;
      addr_d = cnt[ADDR_W-1:0];
      data_d = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      boot_up    <= 1'b0;
      boot_web   <= 1'b1;
      boot_addr  <= '0;
      boot_datai <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      s_ready    <= ready_d;
      boot_up    <= up_d;
      boot_web   <= web_d;
      boot_addr  <= addr_d;
      boot_datai <= data_d;
      busy       <= up_d;
      done       <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt   <= '0;
    end else if (accept_start) begin
      len_q <= len_clamped;
      cnt   <= '0;
    end else if ((state == LOAD) && hs) begin
      cnt <= cnt + ONE;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic sum_mismatch;

  boot_checksum #(
    .DATA_W (DATA_W)
  ) u_checksum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept_start),
    .add_en   ((state == LOAD) && hs),
    .add_data (s_data),
    .cmp_data (s_data),
    .mismatch (sum_mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept_start) begin
      err <= 1'b0;
    end else if ((state == CHECK) && hs && sum_mismatch) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire
